// File: rtl/md_cart_mapper.sv
// rtl/md_cart_mapper.sv - Mega Drive cartridge bank/SRAM mapper with backing-memory request FSM
module md_cart_mapper (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [20:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  input  logic        cart_lwr,
  input  logic        cart_uwr,
  input  logic        cart_time,
  input  logic [15:0] cart_data_wr,
  output logic [15:0] cart_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic        mem_sram,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        sram_en
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q;
  logic        rd_q, rd_d1_q, wr_q, wr_d1_q, tw_q, tw_d1_q;
  logic        rd_start, wr_start, tw_start;
  logic        sram_en_q, sram_wp_q;
  logic [5:0]  bank_q [1:7];
  logic [5:0]  bank_sel;
  logic        sram_win;

  // captured request candidate from this cycle's start
  logic        cap_valid_d, cap_we_d, cap_sram_d;
  logic [1:0]  cap_be_d;
  logic [23:0] cap_addr_d;

  // request actually issued from IDLE: pending slot first, else the fresh start
  logic        iss_valid_d, iss_we_d, iss_sram_d;
  logic [1:0]  iss_be_d;
  logic [23:0] iss_addr_d;
  logic [15:0] iss_wdata_d;

  logic        pend_valid_q, pend_we_q, pend_sram_q;
  logic [1:0]  pend_be_q;
  logic [23:0] pend_addr_q;
  logic [15:0] pend_wdata_q;

  logic        mem_req_q, mem_we_q, mem_sram_q;
  logic [1:0]  mem_be_q;
  logic [23:0] mem_addr_q;
  logic [15:0] mem_wdata_q, cart_data_q;

  assign rd_start = rd_q & ~rd_d1_q;
  assign wr_start = wr_q & ~wr_d1_q;
  assign tw_start = tw_q & ~tw_d1_q;

  // strobe edge detection registers
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0; rd_d1_q <= 1'b0;
      wr_q <= 1'b0; wr_d1_q <= 1'b0;
      tw_q <= 1'b0; tw_d1_q <= 1'b0;
    end else begin
      rd_q    <= cart_cs & cart_oe;
      wr_q    <= cart_cs & (cart_lwr | cart_uwr);
      tw_q    <= cart_time & cart_lwr;
      rd_d1_q <= rd_q;
      wr_d1_q <= wr_q;
      tw_d1_q <= tw_q;
    end
  end

  // $A130xx register writes, handled outside the request FSM
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      sram_en_q <= 1'b0;
      sram_wp_q <= 1'b0;
      for (int i = 1; i <= 7; i++) bank_q[i] <= 6'(i);
    end else if (tw_start) begin
      if (cart_address[6:0] == 7'h78) begin
        sram_en_q <= cart_data_wr[0];
        sram_wp_q <= cart_data_wr[1];
      end else if (cart_address[6:3] == 4'hF && cart_address[2:0] != 3'd0) begin
        bank_q[cart_address[2:0]] <= cart_data_wr[5:0];
      end
    end
  end

  // address decode and start capture
  always_comb begin
    case (cart_address[20:18])
      3'd1:    bank_sel = bank_q[1];
      3'd2:    bank_sel = bank_q[2];
      3'd3:    bank_sel = bank_q[3];
      3'd4:    bank_sel = bank_q[4];
      3'd5:    bank_sel = bank_q[5];
      3'd6:    bank_sel = bank_q[6];
      3'd7:    bank_sel = bank_q[7];
      default: bank_sel = 6'd0;
    endcase
    sram_win   = sram_en_q && (cart_address[20:15] == 6'b100000);
    cap_sram_d = sram_win;
    cap_addr_d = sram_win ? {9'h0, cart_address[14:0]} : {bank_sel, cart_address[17:0]};
    // a write start wins over a simultaneous read start, even when the write is dropped
    cap_valid_d = wr_start ? (sram_win && !sram_wp_q) : rd_start;
    cap_we_d    = wr_start;
    cap_be_d    = wr_start ? {cart_uwr, cart_lwr} : 2'b11;

    iss_valid_d = pend_valid_q | cap_valid_d;
    iss_we_d    = pend_valid_q ? pend_we_q    : cap_we_d;
    iss_sram_d  = pend_valid_q ? pend_sram_q  : cap_sram_d;
    iss_be_d    = pend_valid_q ? pend_be_q    : cap_be_d;
    iss_addr_d  = pend_valid_q ? pend_addr_q  : cap_addr_d;
    iss_wdata_d = pend_valid_q ? pend_wdata_q : cart_data_wr;
  end

  // request FSM with one-deep pending slot and registered bus outputs
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 2'b00;
      mem_sram_q   <= 1'b0;
      mem_addr_q   <= 24'h0;
      mem_wdata_q  <= 16'h0;
      cart_data_q  <= 16'h0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_sram_q  <= 1'b0;
      pend_be_q    <= 2'b00;
      pend_addr_q  <= 24'h0;
      pend_wdata_q <= 16'h0;
    end else begin
      // the slot keeps the newest start unless IDLE consumes it directly
      if (cap_valid_d && !(state_q == IDLE && !pend_valid_q)) begin
        pend_we_q    <= cap_we_d;
        pend_sram_q  <= cap_sram_d;
        pend_be_q    <= cap_be_d;
        pend_addr_q  <= cap_addr_d;
        pend_wdata_q <= cart_data_wr;
      end
      case (state_q)
        IDLE: begin
          pend_valid_q <= pend_valid_q & cap_valid_d;
          if (iss_valid_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= iss_we_d;
            mem_be_q    <= iss_be_d;
            mem_sram_q  <= iss_sram_d;
            mem_addr_q  <= iss_addr_d;
            mem_wdata_q <= iss_wdata_d;
            state_q     <= iss_we_d ? WR : RD;
          end
        end
        RD, WR: begin
          if (cap_valid_d) pend_valid_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (state_q == RD) cart_data_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cart_data = cart_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_sram  = mem_sram_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign sram_en   = sram_en_q;

endmodule

// File: doc/md_cart_mapper.md
MD_CART_MAPPER -- requirements
Module: md_cart_mapper

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- MCLK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cart_address  in  21  68k word address (byte address = {cart_address,1'b0}).
- cart_cs  in  1  cartridge ROM chip select, active-high.
- cart_oe  in  1  read strobe, active-high.
- cart_lwr  in  1  low-byte write strobe, active-high.
- cart_uwr  in  1  high-byte write strobe, active-high.
- cart_time  in  1  $A130xx register window select, active-high.
- cart_data_wr  in  16  write data from the bus.
- cart_data  out  16  read data to the bus.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  request is a write.
- mem_be  out  2  byte enables {upper,lower}.
- mem_sram  out  1  request targets the SRAM space, not the ROM space.
- mem_addr  out  24  word address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  16  read data, valid with mem_ack.
- sram_en  out  1  current SRAM-mapped flag.

Function
REQ-002 SHALL register rd = cart_cs&cart_oe, wr = cart_cs&(cart_lwr|cart_uwr) and tw = cart_time&cart_lwr every MCLK; a start is the registered 0->1 edge of each.
REQ-003 SHALL hold a slot field s = cart_address[20:18] and bank registers bank1..bank7, each 6 bits; slot 0 is fixed at bank 0.
REQ-004 SHALL form the ROM word address as mem_addr = {bank[s], cart_address[17:0]}, with bank[0] = 0.
REQ-005 SHALL decode the SRAM window as sram_en=1 and cart_address[20:15] = 6'b100000 (byte addresses $200000-$20FFFF); in that window, mem_sram = 1 and mem_addr = {9'h0, cart_address[14:0]}.
REQ-006 SHALL, on a tw start, write cart_data_wr[7:0] to the registers selected by cart_address[6:0]:
- 0x78 ($A130F1): sram_en = bit0, sram_wp = bit1.
- 0x79-0x7F ($A130F3-$A130FF): bank1-bank7 = bits[5:0].
- Any other index: ignored.
REQ-007 SHALL complete a tw register write in the cycle after the edge, independent of the FSM and without generating a mem_req.
REQ-008 SHALL implement an FSM with states IDLE, RD, WR.
REQ-009 IDLE -> RD on an rd start: mem_req=1, mem_we=0, mem_be=2'b11 in the next cycle.
REQ-010 IDLE -> WR on a wr start only when the address is in the SRAM window and sram_wp=0: mem_we=1, mem_be={cart_uwr,cart_lwr}, mem_wdata=cart_data_wr, all captured at the edge.
REQ-011 A wr start to ROM space, or to SRAM with sram_wp=1, SHALL be dropped with no request.
REQ-012 SHALL hold mem_req, mem_addr, mem_we, mem_be, mem_sram and mem_wdata stable until mem_ack, then deassert mem_req in the cycle after mem_ack and return to IDLE.
REQ-013 RD SHALL latch mem_rdata into cart_data on mem_ack; cart_data SHALL hold that value until the next read completes.
REQ-014 Strobe deassertion before mem_ack SHALL NOT abort the transaction; it completes and its result is latched normally.
REQ-015 A start arriving while the FSM is not IDLE SHALL set a one-deep pending slot (type, address, data, be); the FSM SHALL issue it in the cycle after returning to IDLE.
REQ-016 Further starts while the pending slot is full SHALL overwrite the pending slot (last wins).
REQ-017 Simultaneous rd and wr starts SHALL give wr priority; the rd start SHALL be dropped.
REQ-018 Minimum read latency SHALL be: edge detected in cycle N, mem_req in N+1, cart_data updated in the cycle after mem_ack.

Reset
REQ-019 While reset is high, SHALL force asynchronously:
- mem_req=0, mem_we=0, mem_be=0, mem_sram=0.
- mem_addr=0, mem_wdata=0, cart_data=0.
- sram_en=0, sram_wp=0.
- bank1..bank7 = 1..7 (identity map).
- pending slot cleared, edge registers = 0, FSM = IDLE.
REQ-020 Reset asserted mid-transaction SHALL drop mem_req at once; a mem_ack received after reset releases SHALL be ignored in IDLE.

Verification
REQ-021 Reset release, rd at cart_address=0x0C0000 (slot 3) -> mem_addr=0x0C0000, mem_sram=0; ack with 0xBEEF -> cart_data=0xBEEF.
REQ-022 tw at index 0x79 with data 0x25, then rd at cart_address=0x041234 -> mem_addr=0x941234.
REQ-023 tw at index 0x78 with data 0x01, then wr at cart_address=0x100010 with lwr only and data 0x00AA -> mem_req, mem_we=1, mem_sram=1, mem_addr=0x000010, mem_be=2'b01, mem_wdata=0x00AA.
REQ-024 wr at cart_address=0x000100 (ROM), and also with sram_wp=1 -> no mem_req; cart_data unchanged.
REQ-025 Second rd start while RD is waiting 5 cycles for ack -> second request issued one cycle after the first completes, with the second address.
REQ-026 Reset pulsed with mem_req high -> mem_req=0 in the same cycle; a later ack is ignored; bank registers read back as the identity map.
